// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA plot geometry, field widths and line-engine state encoding
package vga_pkg;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 3;
    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;
endpackage

// File: rtl/vga_line_draw.sv
// vga_line_draw: Bresenham line engine, one pixel per clock with off-screen pixels clipped
module vga_line_draw
    import vga_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               go,
    output logic               ready,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] color,
    output logic [X_W-1:0]     VGA_X,
    output logic [Y_W-1:0]     VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               done
);
    state_t             state, state_n;
    logic [X_W-1:0]     x, x_end, adx;
    logic [Y_W-1:0]     y, y_end, ady;
    logic [COLOR_W-1:0] color_r;
    logic signed [8:0]  dx, dy;
    logic signed [9:0]  err, err_n, dx_e, dy_e;
    logic signed [10:0] e2;
    logic               sx_neg, sy_neg, step_x, step_y, at_end;

    assign adx    = x_end >= x ? x_end - x : x - x_end;
    assign ady    = y_end >= y ? y_end - y : y - y_end;
    assign at_end = x == x_end && y == y_end;
    assign e2     = $signed({err, 1'b0});
    assign step_x = e2 >= dy;
    assign step_y = e2 <= dx;
    assign dx_e   = {dx[8], dx};
    assign dy_e   = {dy[8], dy};
    assign err_n  = err + (step_x ? dy_e : 10'sd0) + (step_y ? dx_e : 10'sd0);

    assign ready     = state == IDLE;
    assign done      = state == DONE;
    assign plot      = state == DRAW && x < X_W'(H_RES) && y < Y_W'(V_RES);
    assign VGA_X     = x;
    assign VGA_Y     = y;
    assign VGA_COLOR = color_r;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = go ? INIT : IDLE;
            INIT: state_n = DRAW;
            DRAW: state_n = at_end ? DONE : DRAW;
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            x_end   <= '0;
            y_end   <= '0;
            color_r <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (go) begin
                    x       <= x0;
                    y       <= y0;
                    x_end   <= x1;
                    y_end   <= y1;
                    color_r <= color;
                end
                // point registers still hold the start point here
                INIT: begin
                    dx     <= $signed({1'b0, adx});
                    dy     <= -$signed({2'b0, ady});
                    err    <= $signed({2'b0, adx}) - $signed({3'b0, ady});
                    sx_neg <= !(x < x_end);
                    sy_neg <= !(y < y_end);
                end
                DRAW: if (!at_end) begin
                    err <= err_n;
                    if (step_x) x <= x + (sx_neg ? 8'hff : 8'h01);
                    if (step_y) y <= y + (sy_neg ? 7'h7f : 7'h01);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_line_draw.sv
// tb_vga_line_draw: directed and random lines checked cycle by cycle against a Bresenham model
module tb_vga_line_draw;
    import vga_pkg::*;
    logic         CLOCK_50 = 1'b0;
    logic         reset = 1'b1, go = 1'b0;
    logic [7:0]   x0 = '0, x1 = '0;
    logic [6:0]   y0 = '0, y1 = '0;
    logic [2:0]   color = '0;
    logic         ready, plot, done;
    logic [7:0]   VGA_X;
    logic [6:0]   VGA_Y;
    logic [2:0]   VGA_COLOR;
    int           errors = 0, checks = 0;
    int           px[$], py[$];

    vga_line_draw dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .go(go), .ready(ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
        .plot(plot), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic model(input int ax, input int ay, input int bx, input int by);
        int ddx, ddy, sx, sy, e, e2;
        px.delete();
        py.delete();
        ddx = iabs(bx - ax);
        ddy = -iabs(by - ay);
        sx = ax < bx ? 1 : -1;
        sy = ay < by ? 1 : -1;
        e = ddx + ddy;
        forever begin
            px.push_back(ax);
            py.push_back(ay);
            if (ax == bx && ay == by) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e += ddy; ax += sx; end
            if (e2 <= ddx) begin e += ddx; ay += sy; end
        end
    endtask

    task automatic run_line(input int ax, input int ay, input int bx, input int by, input int c);
        int n, plots, exp_plots;
        model(ax, ay, bx, by);
        n = (iabs(bx - ax) > iabs(by - ay) ? iabs(bx - ax) : iabs(by - ay)) + 1;
        check("len", px.size(), n);
        check("ready_idle", ready, 1);
        x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by); color = 3'(c); go = 1'b1;
        @(negedge CLOCK_50);
        go = 1'b0;
        check("init_ready", ready, 0);
        check("init_plot", plot, 0);
        plots = 0;
        exp_plots = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            check("x", VGA_X, px[i]);
            check("y", VGA_Y, py[i]);
            check("plot", plot, px[i] < H_RES && py[i] < V_RES);
            check("draw_done", done, 0);
            plots += int'(plot);
            exp_plots += int'(px[i] < H_RES && py[i] < V_RES);
        end
        check("color", VGA_COLOR, c);
        check("plots", plots, exp_plots);
        @(negedge CLOCK_50);
        check("done", done, 1);
        check("done_plot", plot, 0);
        @(negedge CLOCK_50);
        check("ready_back", ready, 1);
        check("done_low", done, 0);
    endtask

    initial begin
        repeat (2) @(negedge CLOCK_50);
        check("rst_ready", ready, 1);
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_x", VGA_X, 0);
        check("rst_y", VGA_Y, 0);
        check("rst_color", VGA_COLOR, 0);
        reset = 1'b0;
        @(negedge CLOCK_50);
        run_line(10, 20, 15, 20, 4);
        run_line(0, 0, 4, 4, 1);
        run_line(5, 10, 2, 1, 2);
        run_line(7, 7, 7, 7, 7);
        run_line(155, 100, 165, 100, 5);
        run_line(150, 110, 200, 127, 6);
        run_line(255, 127, 0, 0, 3);
        for (int k = 0; k < 25; k++)
            run_line($urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
        // busy: go during DRAW is ignored, then a mid-line reset aborts
        model(0, 0, 100, 50);
        x0 = 0; y0 = 0; x1 = 100; y1 = 50; color = 3'd5; go = 1'b1;
        @(negedge CLOCK_50);
        go = 1'b0;
        @(negedge CLOCK_50);
        x0 = 200; y0 = 90; x1 = 3; y1 = 3; color = 3'd2; go = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge CLOCK_50);
            check("busy_ready", ready, 0);
            check("busy_x", VGA_X, px[i]);
            check("busy_y", VGA_Y, py[i]);
            check("busy_color", VGA_COLOR, 5);
        end
        go = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_plot", plot, 0);
        check("abort_done", done, 0);
        check("abort_x", VGA_X, 0);
        check("abort_y", VGA_Y, 0);
        check("abort_color", VGA_COLOR, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            check("abort_nodone", done, 0);
            check("abort_idle", ready, 1);
        end
        run_line(3, 4, 9, 1, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
